// File: rtl/btb_file_if.sv
// Bundle of IF-side lookup and EX-side update signals for the BTB storage engine.
// The lookup/update side drives master; btb_file receives them through slave.
interface btb_file_if #(
   parameter int SETS    = 8,
   parameter int INDEX_W = 3,
   parameter int TAG_W   = 27
);
   logic [INDEX_W-1:0] read_index;
   logic [127:0]       read_set;
   logic [SETS-1:0]    LRU;
   logic               read_hit;
   logic               next_LRU_read;
   logic               update_en;
   logic [INDEX_W-1:0] update_index;
   logic [TAG_W-1:0]   update_tag;
   logic [31:0]        update_target;
   logic               update_taken;
   logic               update_hit;

   modport master (
      output read_index, read_hit, next_LRU_read,
      output update_en, update_index, update_tag, update_target, update_taken,
      input  read_set, LRU, update_hit
   );

   modport slave (
      input  read_index, read_hit, next_LRU_read,
      input  update_en, update_index, update_tag, update_target, update_taken,
      output read_set, LRU, update_hit
   );
endinterface

// File: rtl/btb_file.sv
// 2-way, 8-set branch target buffer storage: combinational set read for IF,
// 2-bit counter training, target refresh and LRU allocation from EX.
module btb_file #(
   parameter int SETS    = 8,
   parameter int INDEX_W = 3,
   parameter int TAG_W   = 27
) (
   input logic     clk,
   input logic     rst,
   btb_file_if.slave bus
);

   logic [127:0]    mem_q [SETS];
   logic [127:0]    mem_d [SETS];
   logic [SETS-1:0] lru_q;
   logic [SETS-1:0] lru_d;

   logic [127:0] upd_set;
   logic [63:0]  way1;
   logic [63:0]  way2;
   logic         hit1;
   logic         hit2;
   logic [63:0]  new_way;
   logic         write_way2;
   logic         do_write;

   function automatic logic [1:0] next_state(input logic [1:0] s, input logic taken);
      logic [1:0] r;
      if (taken) begin
         r = (s == 2'b00) ? 2'b01 : 2'b10;
      end else begin
         case (s)
            2'b10:   r = 2'b11;
            2'b11:   r = 2'b01;
            default: r = 2'b00;
         endcase
      end
      return r;
   endfunction

   assign upd_set = mem_q[bus.update_index];
   assign way1    = upd_set[127:64];
   assign way2    = upd_set[63:0];
   assign hit1    = way1[63] && (way1[62:36] == bus.update_tag);
   assign hit2    = way2[63] && (way2[62:36] == bus.update_tag);

   assign bus.read_set   = mem_q[bus.read_index];
   assign bus.update_hit = hit1 || hit2;
   assign bus.LRU        = lru_q;

   always_comb begin
      mem_d      = mem_q;
      lru_d      = lru_q;
      new_way    = '0;
      write_way2 = 1'b0;
      do_write   = 1'b0;

      if (bus.read_hit) begin
         lru_d[bus.read_index] = bus.next_LRU_read;
      end

      if (bus.update_en) begin
         if (hit1 || hit2) begin
            // A double match resolves to way1.
            write_way2    = !hit1;
            new_way       = write_way2 ? way2 : way1;
            new_way[3:2]  = next_state(new_way[3:2], bus.update_taken);
            if (bus.update_taken) begin
               new_way[35:4] = bus.update_target;
            end
            do_write = 1'b1;
         end else if (bus.update_taken) begin
            if (!way1[63]) begin
               write_way2 = 1'b0;
            end else if (!way2[63]) begin
               write_way2 = 1'b1;
            end else begin
               // LRU bit set means way2 was used last, so way1 is the victim.
               write_way2 = !lru_q[bus.update_index];
            end
            new_way  = {1'b1, bus.update_tag, bus.update_target, 2'b10, 2'b00};
            do_write = 1'b1;
         end
      end

      // EX is applied after the read side so it wins a same-set LRU collision.
      if (do_write) begin
         if (write_way2) begin
            mem_d[bus.update_index][63:0] = new_way;
         end else begin
            mem_d[bus.update_index][127:64] = new_way;
         end
         lru_d[bus.update_index] = write_way2;
      end
   end

   generate
      for (genvar gi = 0; gi < SETS; gi++) begin : g_set
         always_ff @(posedge clk) begin
            if (rst) begin
               mem_q[gi] <= '0;
            end else begin
               mem_q[gi] <= mem_d[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         lru_q <= '0;
      end else begin
         lru_q <= lru_d;
      end
   end

endmodule

// File: tb/tb_btb_file.sv
// Directed bench for btb_file: stimulus pushes expected set/LRU/hit values into a
// scoreboard queue; a negedge monitor pops and compares against the DUT.
module tb_btb_file;

   typedef struct {
      string        name;
      int           idx;
      logic [127:0] set;
      logic [7:0]   lru;
      logic         hit;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic chk_req = 1'b0;
   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   btb_file_if bus();

   btb_file dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [63:0] mk(input logic v, input logic [26:0] tag,
                                      input logic [31:0] tgt, input logic [1:0] st);
      return {v, tag, tgt, st, 2'b00};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.read_hit      = 1'b0;
      bus.next_LRU_read = 1'b0;
      bus.update_en     = 1'b0;
      bus.update_taken  = 1'b0;
   endtask

   task automatic upd(input int idx, input logic [26:0] tag, input logic [31:0] tgt,
                      input logic taken);
      bus.update_en     = 1'b1;
      bus.update_index  = idx[2:0];
      bus.update_tag    = tag;
      bus.update_target = tgt;
      bus.update_taken  = taken;
      step();
      idle_inputs();
   endtask

   task automatic chk(input string name, input int idx, input logic [127:0] set,
                      input logic [7:0] lru, input logic [26:0] tag, input logic hit);
      exp_t e;
      e.name = name; e.idx = idx; e.set = set; e.lru = lru; e.hit = hit;
      bus.read_index   = idx[2:0];
      bus.update_index = idx[2:0];
      bus.update_tag   = tag;
      exp_q.push_back(e);
      chk_req = 1'b1;
      step();
      chk_req = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_req) begin
         if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard: output with empty queue, got 0 entries, need 1");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 3;
            if (bus.read_set !== e.set) begin
               errors++;
               $display("FAIL %s read_set[%0d]: got %h need %h", e.name, e.idx, bus.read_set, e.set);
            end
            if (bus.LRU !== e.lru) begin
               errors++;
               $display("FAIL %s LRU: got %h need %h", e.name, bus.LRU, e.lru);
            end
            if (bus.update_hit !== e.hit) begin
               errors++;
               $display("FAIL %s update_hit: got %b need %b", e.name, bus.update_hit, e.hit);
            end
            $display("check %s idx=%0d set=%h lru=%h hit=%b", e.name, e.idx,
                     bus.read_set, bus.LRU, bus.update_hit);
         end
      end
   end

   initial begin
      logic [63:0] w1;
      logic [63:0] w2;
      bus.read_index    = '0;
      bus.update_index  = '0;
      bus.update_tag    = '0;
      bus.update_target = '0;
      idle_inputs();

      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         chk("reset", i, 128'h0, 8'h00, 27'h0, 1'b0);
      end

      // Allocation into an empty set, then into the remaining way.
      upd(3, 27'h1234, 32'h80, 1'b1);
      w1 = mk(1'b1, 27'h1234, 32'h80, 2'b10);
      chk("alloc_way1", 3, {w1, 64'h0}, 8'h00, 27'h1234, 1'b1);
      upd(3, 27'h55, 32'h100, 1'b1);
      w2 = mk(1'b1, 27'h55, 32'h100, 2'b10);
      chk("alloc_way2", 3, {w1, w2}, 8'h08, 27'h55, 1'b1);

      // Counter sweep on the way2 entry.
      upd(3, 27'h55, 32'hDEAD, 1'b0);
      chk("nt_10_11", 3, {w1, mk(1'b1, 27'h55, 32'h100, 2'b11)}, 8'h08, 27'h55, 1'b1);
      upd(3, 27'h55, 32'hDEAD, 1'b0);
      chk("nt_11_01", 3, {w1, mk(1'b1, 27'h55, 32'h100, 2'b01)}, 8'h08, 27'h55, 1'b1);
      upd(3, 27'h55, 32'hDEAD, 1'b0);
      chk("nt_01_00", 3, {w1, mk(1'b1, 27'h55, 32'h100, 2'b00)}, 8'h08, 27'h55, 1'b1);
      upd(3, 27'h55, 32'h200, 1'b1);
      chk("t_00_01", 3, {w1, mk(1'b1, 27'h55, 32'h200, 2'b01)}, 8'h08, 27'h55, 1'b1);
      upd(3, 27'h55, 32'h300, 1'b1);
      chk("t_01_10", 3, {w1, mk(1'b1, 27'h55, 32'h300, 2'b10)}, 8'h08, 27'h55, 1'b1);
      upd(3, 27'h55, 32'h400, 1'b1);
      w2 = mk(1'b1, 27'h55, 32'h400, 2'b10);
      chk("t_10_10", 3, {w1, w2}, 8'h08, 27'h55, 1'b1);

      // Full set: LRU victim replacement, then a not-taken miss that must not write.
      upd(3, 27'h77, 32'h500, 1'b1);
      w1 = mk(1'b1, 27'h77, 32'h500, 2'b10);
      chk("replace_way1", 3, {w1, w2}, 8'h00, 27'h1234, 1'b0);
      upd(3, 27'h99, 32'h600, 1'b0);
      chk("nt_miss", 3, {w1, w2}, 8'h00, 27'h99, 1'b0);

      // Read-side and EX LRU writes in the same cycle.
      upd(5, 27'hA, 32'h40, 1'b1);
      chk("alloc_5", 5, {mk(1'b1, 27'hA, 32'h40, 2'b10), 64'h0}, 8'h00, 27'hA, 1'b1);
      bus.read_hit = 1'b1; bus.next_LRU_read = 1'b1; bus.read_index = 3'd5;
      upd(5, 27'hA, 32'h44, 1'b1);
      chk("ex_wins_lru", 5, {mk(1'b1, 27'hA, 32'h44, 2'b10), 64'h0}, 8'h00, 27'hA, 1'b1);
      bus.read_hit = 1'b1; bus.next_LRU_read = 1'b1; bus.read_index = 3'd5;
      upd(6, 27'hB, 32'h60, 1'b1);
      chk("split_lru", 6, {mk(1'b1, 27'hB, 32'h60, 2'b10), 64'h0}, 8'h20, 27'hB, 1'b1);
      bus.read_hit = 1'b1; bus.next_LRU_read = 1'b1; bus.read_index = 3'd0;
      step();
      idle_inputs();
      chk("read_lru", 0, 128'h0, 8'h21, 27'h0, 1'b0);

      // Back-to-back updates on one entry apply in sequence.
      bus.update_en = 1'b1; bus.update_index = 3'd6; bus.update_tag = 27'hB;
      bus.update_target = 32'hFF; bus.update_taken = 1'b0;
      step();
      step();
      idle_inputs();
      chk("b2b_nt", 6, {mk(1'b1, 27'hB, 32'h60, 2'b01), 64'h0}, 8'h21, 27'hB, 1'b1);

      // Reset wins over a same-cycle taken update.
      rst = 1'b1;
      bus.update_en = 1'b1; bus.update_index = 3'd1; bus.update_tag = 27'hC;
      bus.update_target = 32'h70; bus.update_taken = 1'b1;
      step();
      rst = 1'b0;
      idle_inputs();
      chk("rst_upd_1", 1, 128'h0, 8'h00, 27'hC, 1'b0);
      chk("rst_upd_3", 3, 128'h0, 8'h00, 27'h77, 1'b0);
      chk("rst_upd_6", 6, 128'h0, 8'h00, 27'hB, 1'b0);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         step();
      end
      if (exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
